// File: rtl/mixcolumns_seq.sv
// +----------------------------------------------------------------------------+
// | mixcolumns_seq : column-serial AES MixColumns engine with per-block bypass  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module mixcolumn_single (
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic [7:0] s3,
    output logic [7:0] mc0,
    output logic [7:0] mc1,
    output logic [7:0] mc2,
    output logic [7:0] mc3
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign w_x0 = xtime(s0);
    assign w_x1 = xtime(s1);
    assign w_x2 = xtime(s2);
    assign w_x3 = xtime(s3);

    // Rows of the circulant matrix {02 03 01 01}; 03*b is written as 02*b ^ b.
    assign mc0 = w_x0 ^ w_x1 ^ s1 ^ s2 ^ s3;
    assign mc1 = s0 ^ w_x1 ^ w_x2 ^ s2 ^ s3;
    assign mc2 = s0 ^ s1 ^ w_x2 ^ w_x3 ^ s3;
    assign mc3 = w_x0 ^ s0 ^ s1 ^ s2 ^ w_x3;

endmodule

module mixcolumns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [127:0] r_state_buf;
    logic [127:0] r_result;
    logic [1:0]   r_col;
    logic         r_bypass;

    logic [31:0]  w_col_in;
    logic [7:0]   w_mc0, w_mc1, w_mc2, w_mc3;

    // Column c lives at bit offset 32*(3-c); ~col yields 3-col for a 2-bit counter.
    assign w_col_in = r_state_buf[{~r_col, 5'b00000} +: 32];

    mixcolumn_single u_mc (
        .s0  (w_col_in[31:24]),
        .s1  (w_col_in[23:16]),
        .s2  (w_col_in[15:8]),
        .s3  (w_col_in[7:0]),
        .mc0 (w_mc0),
        .mc1 (w_mc1),
        .mc2 (w_mc2),
        .mc3 (w_mc3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)      w_next = in_bypass ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_col == 2'd3) w_next = ST_DONE;
            ST_DONE: if (out_ready)     w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_buf <= 128'h0;
            r_result    <= 128'h0;
            r_col       <= 2'd0;
            r_bypass    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state_buf <= in_data;
                        r_bypass    <= in_bypass;
                        r_col       <= 2'd0;
                        if (in_bypass) begin
                            r_result <= in_data;
                        end
                    end
                end
                ST_RUN: begin
                    // A bypassed block never enters RUN; the guard keeps its result intact regardless.
                    if (!r_bypass) begin
                        r_result[{~r_col, 5'b00000} +: 32] <= {w_mc0, w_mc1, w_mc2, w_mc3};
                    end
                    r_col <= r_col + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mixcolumns_seq.sv
// +----------------------------------------------------------------------------+
// | tb_mixcolumns_seq : directed and random checks of mixcolumns_seq           |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mixcolumns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         ord;
    logic         rnd_mode;
    logic         rnd_bit;

    int           n_cmp;
    int           n_err;
    int           cyc;
    int           acc_q[$];
    logic [127:0] out_q[$];
    logic [127:0] exp_q[$];

    assign out_ready = rnd_mode ? rnd_bit : ord;

    mixcolumns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
        if (rst_n && out_valid && out_ready) out_q.push_back(out_data);
    end

    initial begin
        rnd_bit = 1'b0;
        forever begin
            @(negedge clk);
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        int           m[4][4];
        logic [7:0]   a[4];
        logic [7:0]   acc;
        logic [127:0] res;
        m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++) acc = acc ^ gmul(a[i], m[r][i]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts on a negedge; returns on the negedge where out_valid is first seen.
    task automatic send(input logic [127:0] d, input logic b, output int lat);
        int n;
        in_data   = d;
        in_bypass = b;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 128'(n < 50), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_bypass = 1'($urandom_range(0, 1));
        in_data   = rnd128();
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] BP_IN    = 128'hd4d4d4d5_c6c6c6c6_01010101_db135345;
    localparam logic [127:0] BP_OUT   = 128'hd5d5d7d6_c6c6c6c6_01010101_8e4da1bc;

    initial begin
        int           lat;
        int           n0;
        int           m0;
        int           n;
        logic         seen;
        logic [127:0] blk[3];
        logic [127:0] d3;

        n_cmp = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 128'h0; in_bypass = 1'b0;
        ord = 1'b1; rnd_mode = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_out_data",  out_data,        128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 vector, transform path
        send(FIPS_IN, 1'b0, lat);
        chk("fips_latency", 128'(lat), 128'd5);
        chk("fips_data", out_data, FIPS_OUT);
        chk("fips_model", out_data, mix(FIPS_IN));
        @(posedge clk); @(negedge clk);
        chk("fips_out_valid_drop", 128'(out_valid), 128'd0);
        chk("fips_in_ready_back",  128'(in_ready),  128'd1);

        // Bypass
        send(FIPS_IN, 1'b1, lat);
        chk("bypass_latency", 128'(lat), 128'd1);
        chk("bypass_data", out_data, FIPS_IN);
        @(posedge clk); @(negedge clk);
        chk("bypass_out_valid_drop", 128'(out_valid), 128'd0);

        // Backpressure with in_valid asserted throughout the stall
        ord = 1'b0;
        send(BP_IN, 1'b0, lat);
        chk("bp_latency", 128'(lat), 128'd5);
        d3 = rnd128();
        in_data = d3; in_bypass = 1'b0; in_valid = 1'b1;
        n0 = acc_q.size();
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_data",  out_data,        BP_OUT);
            chk("bp_in_ready",  128'(in_ready),  128'd0);
            @(negedge clk);
        end
        chk("bp_no_accept", 128'(acc_q.size()), 128'(n0));
        ord = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("hs_edge_no_accept", 128'(acc_q.size()), 128'(n0));
        chk("hs_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("post_hs_accept", 128'(acc_q.size()), 128'(n0 + 1));
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("post_hs_data", out_data, mix(d3));
        @(posedge clk); @(negedge clk);

        // Back-to-back with in_valid held high
        for (int i = 0; i < 3; i++) blk[i] = rnd128();
        n0 = acc_q.size(); m0 = out_q.size();
        in_bypass = 1'b0; in_data = blk[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (acc_q.size() < n0 + i + 1 && n < 20) begin @(negedge clk); n++; end
            if (i < 2) in_data = blk[i + 1];
            else       in_valid = 1'b0;
        end
        n = 0;
        while (out_q.size() < m0 + 3 && n < 40) begin @(negedge clk); n++; end
        chk("b2b_count", 128'(out_q.size()), 128'(m0 + 3));
        if (acc_q.size() >= n0 + 3) begin
            chk("b2b_gap01", 128'(acc_q[n0 + 1] - acc_q[n0]),     128'd6);
            chk("b2b_gap12", 128'(acc_q[n0 + 2] - acc_q[n0 + 1]), 128'd6);
        end else begin
            chk("b2b_accepts", 128'(acc_q.size()), 128'(n0 + 3));
        end
        for (int i = 0; i < 3; i++) begin
            if (out_q.size() > m0 + i) chk("b2b_data", out_q[m0 + i], mix(blk[i]));
        end

        // Reset mid-RUN
        send_partial: begin
            in_data = rnd128(); in_bypass = 1'b0; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); @(posedge clk); @(negedge clk);
            chk("pre_rst_busy", 128'(busy), 128'd1);
            m0 = out_q.size();
            rst_n = 1'b0;
            #1;
            chk("midrst_out_valid", 128'(out_valid), 128'd0);
            chk("midrst_in_ready",  128'(in_ready),  128'd1);
            chk("midrst_busy",      128'(busy),      128'd0);
            chk("midrst_out_data",  out_data,        128'h0);
            @(negedge clk);
            rst_n = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            chk("midrst_no_output", 128'(seen), 128'd0);
            chk("midrst_out_count", 128'(out_q.size()), 128'(m0));
        end

        // Random blocks, random gaps, random out_ready
        rnd_mode = 1'b1;
        m0 = out_q.size();
        exp_q.delete();
        for (int k = 0; k < 1000; k++) begin
            logic [127:0] d;
            logic         b;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = rnd128();
            b = 1'($urandom_range(0, 1));
            n0 = acc_q.size();
            in_data = d; in_bypass = b; in_valid = 1'b1;
            n = 0;
            while (acc_q.size() == n0 && n < 200) begin @(negedge clk); n++; end
            in_valid = 1'b0;
            if (n >= 200) chk("rnd_accept_timeout", 128'd1, 128'(n < 200));
            exp_q.push_back(b ? d : mix(d));
        end
        n = 0;
        while (out_q.size() < m0 + 1000 && n < 5000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("rnd_out_count", 128'(out_q.size()), 128'(m0 + 1000));
        for (int k = 0; k < 1000; k++) begin
            if (out_q.size() > m0 + k) chk("rnd_data", out_q[m0 + k], exp_q[k]);
        end
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mixcolumns_seq.md
# mixcolumns_seq

Column-serial MixColumns engine for the AES round datapath. It accepts a full 128-bit state over a valid/ready handshake and sequences its four columns through one shared `mixcolumn_single` instance, one column per clock. It reassembles the result and presents it on an output valid/ready handshake. A per-block `bypass` flag skips the transform for the final AES round, so the round controller uses a single path for every round.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a state block.
- `in_ready`  out  1  block can accept a new state.
- `in_data`  in  128  input state. Column c = `in_data[127-32c -: 32]`. Within a column, s0 is the MSB byte and s3 the LSB byte.
- `in_bypass`  in  1  sampled with `in_data`; 1 = pass the state through unchanged (final round).
- `out_valid`  out  1  `out_data` holds a completed block.
- `out_ready`  in  1  downstream accepts the block.
- `out_data`  out  128  result state, same byte layout as `in_data`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Registers:
  - 128-bit state buffer.
  - 128-bit result buffer.
  - 2-bit column counter `col`.
  - 1-bit bypass flag.
  - FSM.
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `in_data` into the state buffer, capture `in_bypass`, set `col`=0.
  - If bypass is 0, go to RUN.
  - If bypass is 1, copy `in_data` directly into the result buffer and go to DONE.
- **RUN**
  - Each cycle, drive `mixcolumn_single` s0..s3 from state-buffer column `col`.
  - Write mc0..mc3 into result-buffer column `col`, with mc0 as MSB.
  - `col` increments modulo 4.
  - When `col`==3 is written, go to DONE; `col` wraps to 0.
- **DONE**
  - `out_valid`=1, `out_data` = result buffer.
  - On `out_ready`, go to IDLE.
  - `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is high only in IDLE. No overlap: a new block is never accepted while one is in RUN or DONE.
- `in_valid` and `in_bypass` are ignored outside IDLE. Upstream must hold `in_data` and `in_bypass` until `in_ready` is seen.
- The output comes from the result register, not combinationally from `mixcolumn_single`.
- GF(2^8) arithmetic is entirely inside `mixcolumn_single`. This block only routes bytes.
- **Reset (any time, including mid-RUN or DONE)**
  - FSM returns to IDLE, `col`=0, both buffers clear to 0, bypass flag clears to 0.
  - Outputs: `out_valid`=0, `busy`=0, `in_ready`=1, `out_data`=128'h0.
  - The partially processed block is discarded; no output is produced for it.

## Timing
- Accept on edge E0 (non-bypass):
  - RUN spans the cycles after E0.
  - Columns 0, 1, 2 and 3 are written on edges E1, E2, E3 and E4.
  - `out_valid` rises after E4: 5-cycle latency from accept to `out_valid`.
- Bypass: `out_valid` rises after E0 (1-cycle latency).
- If `out_ready` is already high when `out_valid` rises:
  - The output handshake completes at E5.
  - `in_ready` rises after E5.
  - The earliest next accept is E6, giving a peak rate of 1 block per 6 cycles (2 cycles for bypass).
- `out_ready` held low stalls in DONE indefinitely with no data change.
- `in_valid` asserted in the same cycle the output handshake completes is not accepted; `in_ready` is still 0 that cycle.
- `busy` equals (state != IDLE), registered.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-RUN (after E2) -> `out_valid`=0, `in_ready`=1, `busy`=0, `out_data`=0 immediately; no `out_valid` for that block after release.
- **FIPS-197 state, bypass=0:**
  - Stimulus: `in_data`=128'hdb135345_f20a225c_01010101_2d26314c, `out_ready`=1.
  - Required: `out_data`=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, with `out_valid` exactly 5 cycles after accept.
- **Bypass:** same `in_data` with `in_bypass`=1 -> `out_data` equals `in_data`, with `out_valid` 1 cycle after accept.
- **Backpressure:**
  - Stimulus: `in_data`=128'hd4d4d4d5_c6c6c6c6_01010101_db135345, with `out_ready`=0 for 10 cycles.
  - Required: `out_valid` held high, `out_data`=128'hd5d5d7d6_c6c6c6c6_01010101_8e4da1bc stable throughout, and `in_ready`=0 with `in_valid` ignored during the stall.
- **Back-to-back:** `in_valid` held high with 3 different blocks and `out_ready`=1 -> accepts spaced exactly 6 cycles apart, outputs in order, each matching the golden model.
- **Random:** 1000 random blocks with random `bypass`, random `in_valid` gaps and random `out_ready` -> every output matches a software MixColumns model; no drops or duplicates.
